// File: rtl/ysyx_22050854_div_restoring.sv
// ysyx_22050854_div_restoring
// Iterative radix-2 restoring divider for the execute-stage divide unit.
// It produces one quotient bit per cycle and returns RISC-V quotient and
// remainder semantics for div/divu/rem/remu and their W variants.
//
// Ports:
//   clock, reset         single clock; asynchronous active-high reset
//   dividend, divisor    64-bit operands ([31:0] only when divw)
//   div_valid            request, accepted only while div_ready
//   divw                 32-bit operation
//   div_signed           signed operands
//   div_doing            high while iterating
//   div_ready            high when idle and able to accept
//   out_valid            one-cycle pulse; quotient/remainder valid
//   quotient, remainder  results, held until the next completion
module ysyx_22050854_div_restoring (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic        div_valid,
  input  logic        divw,
  input  logic        div_signed,
  output logic        div_doing,
  output logic        div_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] rem_q;   // partial remainder
  logic [63:0] dvd_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [63:0] dvs_q;   // divisor magnitude
  logic        qn_q, rn_q, w_q;

  assign div_ready = (state == S_IDLE);
  assign div_doing = (state == S_BUSY);
  assign out_valid = (state == S_DONE);

  // ---------------- operand preparation (accept cycle) ----------------
  logic [63:0] dvd_ext, dvs_ext, dvd_abs, dvs_abs, dbz_rem;
  logic        dvd_neg, dvs_neg, dvs_zero;

  always_comb begin
    dvd_ext  = divw ? (div_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]})
                    : dividend;
    dvs_ext  = divw ? (div_signed ? {{32{divisor[31]}}, divisor[31:0]} : {32'b0, divisor[31:0]})
                    : divisor;
    dvd_neg  = div_signed & dvd_ext[63];
    dvs_neg  = div_signed & dvs_ext[63];
    dvd_abs  = dvd_neg ? (~dvd_ext + 64'd1) : dvd_ext;
    dvs_abs  = dvs_neg ? (~dvs_ext + 64'd1) : dvs_ext;
    dvs_zero = (dvs_ext == 64'd0);
    // Divide-by-zero remainder is the prepared dividend, W results sign-extended from bit 31
    dbz_rem  = divw ? {{32{dvd_ext[31]}}, dvd_ext[31:0]} : dvd_ext;
  end

  // ---------------- one restoring step ----------------
  logic [64:0] part, diff;
  logic        qbit;
  logic [63:0] rem_nx, dvd_nx;

  always_comb begin
    part   = {rem_q, dvd_q[63]};
    diff   = part - {1'b0, dvs_q};
    // rem_q < divisor always holds, so bit 64 of the difference is its sign
    qbit   = ~diff[64];
    rem_nx = qbit ? diff[63:0] : part[63:0];
    dvd_nx = {dvd_q[62:0], qbit};
  end

  // ---------------- sign fixup of the final step ----------------
  logic [63:0] q_mag, q_sg, r_sg, q_fin, r_fin;
  logic        last;

  always_comb begin
    // In W mode the low 32 bits hold the quotient; the upper bits are
    // the zero padding from the pre-shift, shifted up.
    q_mag = w_q ? {32'b0, dvd_nx[31:0]} : dvd_nx;
    q_sg  = qn_q ? (~q_mag + 64'd1) : q_mag;
    r_sg  = rn_q ? (~rem_nx + 64'd1) : rem_nx;
    q_fin = w_q ? {{32{q_sg[31]}}, q_sg[31:0]} : q_sg;
    r_fin = w_q ? {{32{r_sg[31]}}, r_sg[31:0]} : r_sg;
    last  = (cnt == (w_q ? 6'd31 : 6'd63));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      rem_q     <= 64'd0;
      dvd_q     <= 64'd0;
      dvs_q     <= 64'd0;
      qn_q      <= 1'b0;
      rn_q      <= 1'b0;
      w_q       <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 64'd0;
    end else begin
      case (state)
        S_IDLE: if (div_valid) begin
          w_q   <= divw;
          qn_q  <= dvd_neg ^ dvs_neg;
          rn_q  <= dvd_neg;
          dvs_q <= dvs_abs;
          rem_q <= 64'd0;
          cnt   <= 6'd0;
          // W operations start with the 32-bit magnitude at the top
          dvd_q <= divw ? {dvd_abs[31:0], 32'b0} : dvd_abs;
          if (dvs_zero) begin
            state     <= S_DONE;
            quotient  <= '1;
            remainder <= dbz_rem;
          end else begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          cnt   <= cnt + 6'd1;
          if (last) begin
            state     <= S_DONE;
            cnt       <= 6'd0;
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
